// File: rtl/binary_to_decimal.sv
// binary_to_decimal: signed 32-bit to 10-digit BCD converter (double dabble, 33-cycle latency).
// Also reports the sign and the count of significant digits for leading-zero blanking.
`default_nettype none

module binary_to_decimal (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] din,
  output logic        busy,
  output logic        done,
  output logic [39:0] bcd,
  output logic        neg,
  output logic [3:0]  ndigits
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [39:0] scratch;
  logic [39:0] scratch_adj;
  logic [31:0] mag;
  logic [31:0] din_abs;
  logic [4:0]  cnt;
  logic        neg_r;
  logic [3:0]  ndig_calc;

  // Unsigned negation keeps 32'h8000_0000 as 2147483648.
  assign din_abs = din[31] ? (~din + 32'd1) : din;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (cnt == 5'd31) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    scratch_adj = scratch;
    for (int i = 0; i < 10; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) begin
        scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
    end
  end

  // Ascending scan: the last nonzero digit seen is the most significant one.
  always_comb begin
    ndig_calc = 4'd1;
    for (int i = 0; i < 10; i++) begin
      if (scratch[4*i +: 4] != 4'd0) begin
        ndig_calc = 4'(i + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scratch <= 40'd0;
      mag     <= 32'd0;
      cnt     <= 5'd0;
      neg_r   <= 1'b0;
      bcd     <= 40'd0;
      neg     <= 1'b0;
      ndigits <= 4'd1;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            neg_r   <= din[31];
            mag     <= din_abs;
            scratch <= 40'd0;
            cnt     <= 5'd0;
          end
        end
        SHIFT: begin
          scratch <= {scratch_adj[38:0], mag[31]};
          mag     <= {mag[30:0], 1'b0};
          cnt     <= cnt + 5'd1;
        end
        FINISH: begin
          bcd     <= scratch;
          neg     <= neg_r & (|scratch);
          ndigits <= ndig_calc;
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_binary_to_decimal.sv
// tb_binary_to_decimal: scoreboard bench; stimulus pushes expected results, a monitor checks each done.
`default_nettype none

module tb_binary_to_decimal;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] din;
  logic        busy;
  logic        done;
  logic [39:0] bcd;
  logic        neg;
  logic [3:0]  ndigits;

  typedef struct {
    logic [39:0] bcd;
    logic        neg;
    logic [3:0]  nd;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  logic prev_done = 1'b0;

  binary_to_decimal dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .din     (din),
    .busy    (busy),
    .done    (done),
    .bcd     (bcd),
    .neg     (neg),
    .ndigits (ndigits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      chk("done_single_pulse", {63'd0, prev_done}, 64'd0);
      chk("busy_in_done", {63'd0, busy}, 64'd0);
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("bcd", {24'd0, bcd}, {24'd0, e.bcd});
        chk("neg", {63'd0, neg}, {63'd0, e.neg});
        chk("ndigits", {60'd0, ndigits}, {60'd0, e.nd});
        chk("latency", 64'(cyc - e.acc), 64'd33);
      end
    end
    prev_done <= done;
  end

  // Presents start for one edge; returns #1 after that edge.
  task automatic issue(input logic [31:0] v, input bit expect_done,
                       input logic [39:0] eb, input logic en, input logic [3:0] end_);
    exp_t e;
    start = 1'b1;
    din   = v;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (expect_done) begin
      e.bcd = eb; e.neg = en; e.nd = end_; e.acc = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("done_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    repeat (40) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; din = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_bcd", {24'd0, bcd}, 64'd0);
    chk("rst_neg", {63'd0, neg}, 64'd0);
    chk("rst_ndigits", {60'd0, ndigits}, 64'd1);
    rst = 1'b0;

    issue(32'd0, 1'b1, 40'h00_0000_0000, 1'b0, 4'd1);
    chk("busy_after_accept", {63'd0, busy}, 64'd1);
    drain();
    issue(32'h7FFF_FFFF, 1'b1, 40'h21_4748_3647, 1'b0, 4'd10);
    drain();
    issue(32'h8000_0000, 1'b1, 40'h21_4748_3648, 1'b1, 4'd10);
    drain();
    issue(32'hFFFF_FFFF, 1'b1, 40'h00_0000_0001, 1'b1, 4'd1);
    drain();
    issue(32'd10, 1'b1, 40'h00_0000_0010, 1'b0, 4'd2);
    drain();
    issue(32'd999999999, 1'b1, 40'h09_9999_9999, 1'b0, 4'd9);
    drain();

    // Back-to-back: second start lands in the done cycle of the first.
    issue(32'hFFFF_FB4B, 1'b1, 40'h00_0000_1205, 1'b1, 4'd4);
    repeat (33) @(posedge clk);
    #1;
    chk("b2b_done_cycle", {63'd0, done}, 64'd1);
    issue(32'd7, 1'b1, 40'h00_0000_0007, 1'b0, 4'd1);
    drain();
    chk("idle_hold_bcd", {24'd0, bcd}, 64'h7);

    // Start while busy must be ignored; outputs hold the previous result.
    issue(32'd1000, 1'b1, 40'h00_0000_1000, 1'b0, 4'd4);
    repeat (9) @(posedge clk);
    #1;
    chk("busy_mid", {63'd0, busy}, 64'd1);
    chk("hold_bcd_mid", {24'd0, bcd}, 64'h7);
    issue(32'd5, 1'b0, 40'd0, 1'b0, 4'd0);
    drain();

    // Reset mid-conversion aborts with no done.
    issue(32'd12345, 1'b0, 40'd0, 1'b0, 4'd0);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_bcd", {24'd0, bcd}, 64'd0);
    chk("abort_ndigits", {60'd0, ndigits}, 64'd1);
    chk("abort_neg", {63'd0, neg}, 64'd0);
    rst = 1'b0;
    drain();
    issue(32'd12345, 1'b1, 40'h00_0001_2345, 1'b0, 4'd5);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
